// File: rtl/ctm_pkg.sv
// Shared types and helpers for the ciphertext tensor MAC.
// Reduction helper is used only when CTM_MOD_REDUCE_EN is defined.
package ctm_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    MAC    = 2'd1,
    DRAIN  = 2'd2
  } ctm_state_e;

  function automatic logic [63:0] ctm_mod(input logic [63:0] x, input logic [63:0] q);
    return x % q;
  endfunction

endpackage

// File: rtl/ctm_modmul.sv
// One coefficient lane: acc_out = acc_in + coef*scale, reduced mod MODULUS when
// CTM_MOD_REDUCE_EN is defined, otherwise a plain wide accumulate.
module ctm_modmul
  import ctm_pkg::*;
#(
  parameter int MODULUS = 1024,
  parameter int W       = 10,
  parameter int ACC_W   = 2*W + 1
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [W-1:0]     coef,
  input  logic [W-1:0]     scale,
  output logic [ACC_W-1:0] acc_out
);

  logic [2*W-1:0] prod;

  // Full 2W-bit product so nothing overflows before the add/reduce.
  assign prod = (2*W)'(coef) * (2*W)'(scale);

`ifdef CTM_MOD_REDUCE_EN
  assign acc_out = ACC_W'(ctm_mod(64'(acc_in) + 64'(prod), 64'(MODULUS)));
`else
  assign acc_out = acc_in + ACC_W'(prod);
`endif

endmodule

// File: rtl/ciphertext_tensor_mac.sv
// Ciphertext tensor MAC: loads operand A, streams operand B rows into a
// polynomial-product accumulator, then drains 2D+1 results. Macro: CTM_MOD_REDUCE_EN.
module ciphertext_tensor_mac
  import ctm_pkg::*;
#(
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 1,
  localparam int IDX_WIDTH = ($clog2(2*DIMENSION+1) < 1) ? 1 : $clog2(2*DIMENSION+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        one_valid,
  output logic                        one_ready,
  input  logic [IDX_WIDTH-1:0]        one_row,
  input  logic [CIPHERTEXT_WIDTH-1:0] one_entry,
  input  logic                        two_valid,
  output logic                        two_ready,
  input  logic [IDX_WIDTH-1:0]        two_row,
  input  logic [CIPHERTEXT_WIDTH-1:0] two_entry,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] res_entry,
  output logic [IDX_WIDTH-1:0]        res_idx,
  output logic                        res_last,
  output logic                        busy,
  output logic                        err
);

  localparam int W     = CIPHERTEXT_WIDTH;
  localparam int NA    = DIMENSION + 1;
  localparam int NR    = 2*DIMENSION + 1;
  localparam int CNT_W = $clog2(NA + 1);
`ifdef CTM_MOD_REDUCE_EN
  localparam int ACC_W = W;
`else
  localparam int ACC_W = 2*W + $clog2(NA);
`endif
  localparam logic [IDX_WIDTH-1:0] MAX_ROW  = IDX_WIDTH'(DIMENSION);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(2*DIMENSION);

  ctm_state_e           state, state_nxt;
  logic [W-1:0]         a      [NA];
  logic [ACC_W-1:0]     acc    [NR];
  logic [ACC_W-1:0]     mm_in  [NA];
  logic [ACC_W-1:0]     mm_out [NA];
  logic [IDX_WIDTH-1:0] tgt    [NA];
  logic [NA-1:0]        a_mask, a_mask_nxt, b_mask, a_oh, b_oh;
  logic [CNT_W-1:0]     b_cnt;
  logic [ACC_W-1:0]     res_sel;
  logic [W-1:0]         a_store;
  logic                 a_ok, b_ok, b_dup, a_fire, b_fire, drain_fire, bad;

`ifdef CTM_MOD_REDUCE_EN
  assign a_store = W'(ctm_mod(64'(one_entry), 64'(CIPHERTEXT_MODULUS)));
`else
  assign a_store = one_entry;
`endif

  always_comb begin
    one_ready = (state == LOAD_A);
    two_ready = (state == MAC);
    res_valid = (state == DRAIN);
    res_last  = res_valid && (res_idx == LAST_IDX);
    busy      = (state != LOAD_A) || (|a_mask);

    a_ok       = (one_row <= MAX_ROW);
    b_ok       = (two_row <= MAX_ROW);
    a_oh       = NA'(1) << one_row;
    b_oh       = NA'(1) << two_row;
    b_dup      = |(b_mask & b_oh);
    a_fire     = one_valid && one_ready && a_ok;
    b_fire     = two_valid && two_ready && b_ok && !b_dup;
    drain_fire = res_valid && res_ready;
    bad        = (one_valid && one_ready && !a_ok) ||
                 (two_valid && two_ready && (!b_ok || b_dup));
    a_mask_nxt = a_fire ? (a_mask | a_oh) : a_mask;

    // Lane n of a B beat lands on acc[two_row+n]; fetch those operands.
    for (int n = 0; n < NA; n++) begin
      tgt[n]   = two_row + IDX_WIDTH'(n);
      mm_in[n] = '0;
      for (int k = 0; k < NR; k++)
        if (tgt[n] == IDX_WIDTH'(k)) mm_in[n] = acc[k];
    end

    res_sel = '0;
    for (int k = 0; k < NR; k++)
      if (res_idx == IDX_WIDTH'(k)) res_sel = acc[k];
    res_entry = res_valid ? W'(res_sel) : '0;

    state_nxt = state;
    case (state)
      LOAD_A:  if (&a_mask_nxt) state_nxt = MAC;
      MAC:     if (b_fire && (b_cnt == CNT_W'(DIMENSION))) state_nxt = DRAIN;
      DRAIN:   if (drain_fire && res_last) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  for (genvar n = 0; n < NA; n++) begin : g_lane
    ctm_modmul #(
      .MODULUS (CIPHERTEXT_MODULUS),
      .W       (W),
      .ACC_W   (ACC_W)
    ) u_modmul (
      .acc_in  (mm_in[n]),
      .coef    (a[n]),
      .scale   (two_entry),
      .acc_out (mm_out[n])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD_A;
      a_mask  <= '0;
      b_mask  <= '0;
      b_cnt   <= '0;
      res_idx <= '0;
      err     <= 1'b0;
      for (int n = 0; n < NA; n++) a[n] <= '0;
      for (int k = 0; k < NR; k++) acc[k] <= '0;
    end else begin
      state <= state_nxt;
      err   <= err | bad;
      if (a_fire) begin
        a_mask <= a_mask_nxt;
        for (int n = 0; n < NA; n++)
          if (a_oh[n]) a[n] <= a_store;
      end
      if (b_fire) begin
        b_mask <= b_mask | b_oh;
        b_cnt  <= b_cnt + CNT_W'(1);
        for (int k = 0; k < NR; k++)
          for (int n = 0; n < NA; n++)
            if (tgt[n] == IDX_WIDTH'(k)) acc[k] <= mm_out[n];
      end
      // Closing beat starts a fresh operation; a[] is kept but must be reloaded.
      if (drain_fire) begin
        if (res_last) begin
          res_idx <= '0;
          a_mask  <= '0;
          b_mask  <= '0;
          b_cnt   <= '0;
          for (int k = 0; k < NR; k++) acc[k] <= '0;
        end else begin
          res_idx <= res_idx + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule
